// File: rtl/network_sdiv_30s_16s_14s_seq.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | network_sdiv_30s_16s_14s_seq: sequential restoring signed divide, saturating |
// | Revision 1.0                                                                 |
// +------------------------------------------------------------------------------+
module network_sdiv_30s_16s_14s_seq #(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = 30,
  parameter int DIVISOR_WIDTH  = 16,
  parameter int QUOT_WIDTH     = 14
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic                            ap_start,
  output logic                            ap_done,
  output logic                            ap_idle,
  output logic                            ap_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] din0,
  input  logic signed [DIVISOR_WIDTH-1:0]  din1,
  output logic signed [QUOT_WIDTH-1:0]     quot,
  output logic signed [DIVISOR_WIDTH-1:0]  rem,
  output logic                            ovf
);

  localparam int DW    = DIVIDEND_WIDTH;
  localparam int DS    = DIVISOR_WIDTH;
  localparam int QW    = QUOT_WIDTH;
  localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;

  localparam logic [DW-1:0]  c_Q_POS_MAG = DW'((1 << (QW - 1)) - 1);
  localparam logic [DW-1:0]  c_Q_NEG_MAG = DW'(1 << (QW - 1));
  localparam logic [QW-1:0]  c_Q_MAX     = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0]  c_Q_MIN     = {1'b1, {(QW-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(DIVIDEND_WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_dvd;   // dividend magnitude, shifts out MSB-first, quotient shifts in
  logic [DS-1:0]    r_dvs;
  logic [DS:0]      r_pr;
  logic             r_s0;
  logic             r_s1;
  logic             r_dz;
  logic             r_done;
  logic [QW-1:0]    r_quot;
  logic [DS-1:0]    r_rem;
  logic             r_ovf;

  logic [DW-1:0]    w_abs0;
  logic [DS-1:0]    w_abs1;
  logic [DS:0]      w_sh;
  logic [DS:0]      w_diff;
  logic             w_ge;
  logic             w_neg;
  logic [QW-1:0]    w_quot;
  logic [DS-1:0]    w_rem;
  logic             w_ovf;

  assign w_abs0 = din0[DW-1] ? DW'(-din0) : din0;
  assign w_abs1 = din1[DS-1] ? DS'(-din1) : din1;

  assign w_sh   = {r_pr[DS-1:0], r_dvd[DW-1]};
  assign w_ge   = (w_sh >= {1'b0, r_dvs});
  assign w_diff = w_sh - {1'b0, r_dvs};
  assign w_neg  = r_s0 ^ r_s1;

  always_comb begin
    w_quot = '0;
    w_ovf  = 1'b0;
    w_rem  = r_s0 ? DS'(-r_pr[DS-1:0]) : r_pr[DS-1:0];
    if (r_dz) begin
      w_quot = r_s0 ? c_Q_MIN : c_Q_MAX;
      w_rem  = '0;
      w_ovf  = 1'b1;
    end else if (!w_neg && (r_dvd > c_Q_POS_MAG)) begin
      w_quot = c_Q_MAX;
      w_ovf  = 1'b1;
    end else if (w_neg && (r_dvd > c_Q_NEG_MAG)) begin
      w_quot = c_Q_MIN;
      w_ovf  = 1'b1;
    end else begin
      w_quot = w_neg ? QW'(-r_dvd[QW-1:0]) : r_dvd[QW-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_pr    <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (ap_start) begin
            r_dvd   <= w_abs0;
            r_dvs   <= w_abs1;
            r_s0    <= din0[DW-1];
            r_s1    <= din1[DS-1];
            r_dz    <= (din1 == '0);
            r_pr    <= '0;
            r_cnt   <= '0;
            r_state <= c_CALC;
          end
        end
        c_CALC: begin
          r_pr  <= w_ge ? w_diff : w_sh;
          r_dvd <= {r_dvd[DW-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= c_FIX;
          end
        end
        c_FIX: begin
          r_quot  <= w_quot;
          r_rem   <= w_rem;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign ap_done  = r_done;
  assign ap_ready = r_done;
  assign ap_idle  = (r_state == c_IDLE);
  assign quot     = r_quot;
  assign rem      = r_rem;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_network_sdiv_30s_16s_14s_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_network_sdiv_30s_16s_14s_seq: directed checks of the sequential divider |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_network_sdiv_30s_16s_14s_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               ap_start;
  logic               ap_done;
  logic               ap_idle;
  logic               ap_ready;
  logic signed [29:0] din0;
  logic signed [15:0] din1;
  logic signed [13:0] quot;
  logic signed [15:0] rem;
  logic               ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ap_clk = ~ap_clk;

  network_sdiv_30s_16s_14s_seq dut (
    .ap_clk  (ap_clk),
    .ap_rst  (ap_rst),
    .ap_start(ap_start),
    .ap_done (ap_done),
    .ap_idle (ap_idle),
    .ap_ready(ap_ready),
    .din0    (din0),
    .din1    (din1),
    .quot    (quot),
    .rem     (rem),
    .ovf     (ovf)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ap_done; k is the edge count after the start edge, -1 on timeout.
  task automatic wait_done(output int k, output bit idle_ok);
    k       = -1;
    idle_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge ap_clk);
      #1;
      if (ap_done) begin
        k = i;
        break;
      end
      if (ap_idle) idle_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b,
                        input int eq, input int er, input int eo);
    int k;
    bit idle_ok;
    din0     = 30'(a);
    din1     = 16'(b);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0     = 30'h1555_5555;
    din1     = 16'h7abc;
    wait_done(k, idle_ok);
    chk({tag, " latency"}, k, 31);
    chk({tag, " quot"}, int'(quot), eq);
    chk({tag, " rem"}, int'(rem), er);
    chk({tag, " ovf"}, int'(ovf), eo);
    chk({tag, " ready"}, int'(ap_ready), 1);
    chk({tag, " idle_calc"}, int'(idle_ok), 1);
    chk({tag, " idle_done"}, int'(ap_idle), 1);
  endtask

  initial begin
    int k1, k2;
    bit ok1, ok2;
    bit seen;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    din0     = '0;
    din1     = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("reset quot", int'(quot), 0);
    chk("reset rem", int'(rem), 0);
    chk("reset ovf", int'(ovf), 0);
    chk("reset done", int'(ap_done), 0);
    chk("reset idle", int'(ap_idle), 1);

    run_op("pos",     1000000,    123,   8130,  10, 0);
    chk("done pulse", int'(ap_done), 1);
    @(posedge ap_clk);
    #1;
    chk("done single", int'(ap_done), 0);
    run_op("neg",    -1000000,    123,  -8130, -10, 0);
    run_op("bigdiv",      100, -32768,      0, 100, 0);
    run_op("satneg",   999999,     -7,  -8192,   0, 1);
    run_op("satmin", -536870912,   -1,   8191,   0, 1);
    run_op("max",        8191,      1,   8191,   0, 0);
    run_op("min",       -8192,      1,  -8192,   0, 0);
    run_op("dz pos",        5,      0,   8191,   0, 1);
    run_op("dz neg",       -5,      0,  -8192,   0, 1);

    // back-to-back with ap_start held; inputs swapped right after each capture
    din0     = 30'(1000000);
    din1     = 16'(123);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    din0 = 30'(-1000000);
    din1 = 16'(123);
    wait_done(k1, ok1);
    chk("b2b first latency", k1, 31);
    chk("b2b first quot", int'(quot), 8130);
    chk("b2b first rem", int'(rem), 10);
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    din0     = 30'(5);
    din1     = 16'(0);
    chk("b2b done gap", int'(ap_done), 0);
    chk("b2b busy", int'(ap_idle), 0);
    wait_done(k2, ok2);
    chk("b2b spacing", k2 + 1, 32);
    chk("b2b second quot", int'(quot), -8130);
    chk("b2b second rem", int'(rem), -10);
    chk("b2b second ovf", int'(ovf), 0);

    // reset in the middle of CALC discards the operation
    din0     = 30'(999999);
    din1     = 16'(-7);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    chk("rst quot", int'(quot), 0);
    chk("rst rem", int'(rem), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst idle", int'(ap_idle), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ap_clk);
      #1;
      if (ap_done) seen = 1'b1;
    end
    chk("rst no done", int'(seen), 0);
    run_op("after rst", 1000000, 123, 8130, 10, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/network_sdiv_30s_16s_14s_seq.md
# network_sdiv_30s_16s_14s_seq

Sequential signed divider that undoes the scaling of the 14s×16s→30s multiply path. It divides a 30-bit signed product/accumulator by a 16-bit signed scale and returns a 14-bit saturated signed quotient plus the remainder. The block sits in the network datapath wherever a 30-bit intermediate must be rescaled back to activation width. It uses HLS block-level handshake (ap_start/ap_done/ap_idle/ap_ready) so it drops in beside generated cores.

## Interface
- ID, 1, instance identifier; no functional effect.
- DIVIDEND_WIDTH, 30, din0 width; also the iteration count.
- DIVISOR_WIDTH, 16, din1 and rem width.
- QUOT_WIDTH, 14, quot width (saturation range).

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_start  in  1  request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse; quot/rem/ovf valid.
- ap_idle  out  1  high while state is IDLE (combinational from state).
- ap_ready  out  1  identical to ap_done.
- din0  in  DIVIDEND_WIDTH  signed dividend.
- din1  in  DIVISOR_WIDTH  signed divisor.
- quot  out  QUOT_WIDTH  signed quotient, truncated toward zero, saturated.
- rem  out  DIVISOR_WIDTH  signed remainder; sign follows the dividend; |rem| < |din1|.
- ovf  out  1  high if quot saturated or din1 was zero.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with ap_start=1:
  - Capture |din0| (DIVIDEND_WIDTH bits unsigned), |din1| (DIVISOR_WIDTH bits unsigned), both sign bits and a divisor-zero flag.
  - Clear the partial remainder. Set counter=0. Go to CALC.
  - Inputs are don't-care after this capture.
- CALC: one restoring step per cycle, MSB first.
  - Shift the partial remainder left one bit and bring in the next dividend bit.
  - If partial remainder ≥ |divisor|, subtract and shift 1 into the quotient; else shift in 0.
  - The partial remainder is DIVISOR_WIDTH+1 bits wide.
  - After counter reaches DIVIDEND_WIDTH-1, go to FIX.
- FIX: register the outputs, set ap_done=1, go to IDLE.
  - Signed quotient: the magnitude, negated if the operand signs differ.
  - Saturate to [-2^(QUOT_WIDTH-1), 2^(QUOT_WIDTH-1)-1], i.e. [-8192, 8191]. Saturation sets ovf=1.
  - rem: the remainder magnitude, negated if the dividend is negative. rem is the true remainder even when quot saturates.
  - din1=0: quot=8191 if din0≥0, else -8192; rem=0; ovf=1.
- quot, rem and ovf hold until the next FIX. They are not cleared by a new ap_start.
- Corner cases:
  - din0=-2^29 with din1=-1 gives magnitude 2^29, so quot=8191, ovf=1, rem=0.
  - din1=-32768 has magnitude 32768, which fits unsigned and is handled normally.
- ap_rst=1 at any edge, including mid-CALC or FIX:
  - State goes to IDLE. quot=0, rem=0, ovf=0, ap_done=0.
  - The in-flight operation is discarded and no ap_done is produced.
  - ap_idle=1 in the cycle after reset.

## Timing
- ap_start is sampled high in IDLE at edge t. CALC then runs on edges t+1 … t+DIVIDEND_WIDTH.
- FIX registers the outputs at edge t+DIVIDEND_WIDTH+1 (t+31 by default).
- ap_done, ap_ready and valid outputs are high in the cycle after edge t+31. Latency is 31 cycles.
- ap_idle is low from the cycle after t until FIX completes. It is high during the ap_done cycle.
- With ap_start held high, the next operation is accepted at edge t+32. Throughput is one operation per 32 cycles.
- ap_done is never high for two consecutive cycles.
- ap_start while not in IDLE is ignored; there is no queueing.

## Test plan
- 1000000 / 123, start at edge t:
  - quot=8130, rem=10, ovf=0.
  - ap_done high exactly in the cycle after edge t+31; ap_idle low throughout CALC.
- -1000000 / 123 → quot=-8130, rem=-10, ovf=0.
- 100 / -32768 → quot=0, rem=100, ovf=0.
- Saturation and boundary quotients:
  - 999999 / -7 → quot=-8192, rem=0, ovf=1.
  - -536870912 / -1 → quot=8191, rem=0, ovf=1.
  - 8191 / 1 → quot=8191, ovf=0.
  - -8192 / 1 → quot=-8192, ovf=0.
- Divide by zero:
  - 5 / 0 → quot=8191, rem=0, ovf=1.
  - -5 / 0 → quot=-8192, rem=0, ovf=1.
- Control:
  - ap_start held high for two operations → the second ap_done comes 32 cycles after the first. Both results are correct, and input changes after capture have no effect.
  - ap_rst pulsed at CALC cycle 10 → no ap_done, then quot=0, rem=0, ovf=0, ap_idle=1. A following operation completes normally.
